// File: rtl/lcd_msg_sequencer_pkg.sv
// Shared types and the fixed message table for the LCD message sequencer.
// Every message is exactly LCD_MSG_LEN characters, space padded; the last entry is UNKNOWN.
package lcd_pkg;

    localparam int         LCD_NUM_CLASSES = 4;
    localparam int         LCD_MSG_LEN     = 16;
    localparam int         LCD_IDX_W       = $clog2(LCD_MSG_LEN);
    localparam logic [7:0] LCD_SPACE       = 8'h20;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_SEND,
        SEQ_WAIT_LOW,
        SEQ_WAIT_HIGH,
        SEQ_DONE
    } lcd_seq_state_t;

    typedef logic [8*LCD_MSG_LEN-1:0] lcd_msg_t;

    // First character sits in the most significant byte.
    localparam lcd_msg_t LCD_MSG_TABLE [LCD_NUM_CLASSES+1] = '{
        {"YES",     {13{LCD_SPACE}}},
        {"NO",      {14{LCD_SPACE}}},
        {"UP",      {14{LCD_SPACE}}},
        {"DOWN",    {12{LCD_SPACE}}},
        {"UNKNOWN", {9{LCD_SPACE}}}
    };

    function automatic logic [7:0] lcd_msg_char(input lcd_msg_t msg,
                                                input logic [LCD_IDX_W-1:0] idx);
        return msg[8*(LCD_MSG_LEN-1-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/lcd_msg_sequencer_if.sv
// Classifier-result and LCD character handshake bundle for lcd_msg_sequencer.
// master = classifier/LCD-driver side, slave = the sequencer.
interface lcd_msg_sequencer_if #(
    parameter int CLASS_W = 3
);
    logic               class_valid;
    logic [CLASS_W-1:0] class_id;
    logic               char_ready;
    logic               char_valid;
    logic [7:0]         char_out;
    logic               busy;
    logic               msg_done;
    logic               err;

    modport master (
        output class_valid, class_id, char_ready,
        input  char_valid, char_out, busy, msg_done, err
    );

    modport slave (
        input  class_valid, class_id, char_ready,
        output char_valid, char_out, busy, msg_done, err
    );
endinterface

// File: rtl/lcd_msg_rom.sv
// Combinational (class, index) -> ASCII lookup into the package message table.
// Classes at or beyond NUM_CLASSES resolve to the UNKNOWN message.
module lcd_msg_rom
    import lcd_pkg::*;
#(
    parameter int NUM_CLASSES = LCD_NUM_CLASSES,
    parameter int CLASS_W     = 3
) (
    input  logic [CLASS_W-1:0]   class_id,
    input  logic [LCD_IDX_W-1:0] idx,
    output logic [7:0]           char_code
);
    lcd_msg_t msg;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        msg = LCD_MSG_TABLE[LCD_NUM_CLASSES];
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (class_id == CLASS_W'(c)) msg = LCD_MSG_TABLE[c];
        end
        char_code = lcd_msg_char(msg, idx);
    end
endmodule

// File: rtl/lcd_msg_sequencer.sv
// Streams the fixed ASCII message of a classifier result to the LCD driver, one char per handshake.
// Optional build macro: LCD_SEQ_REPEAT_SUPPRESS_EN (drop repeats of the last completed message).
module lcd_msg_sequencer
    import lcd_pkg::*;
#(
    parameter int NUM_CLASSES = LCD_NUM_CLASSES,
    parameter int CLASS_W     = 3,
    parameter int MSG_LEN     = LCD_MSG_LEN,  // must match the package table width
    parameter int ACK_TIMEOUT = 4095
) (
    input  logic                clk,
    input  logic                rstb,
    lcd_msg_sequencer_if.slave  bus
);
    localparam int IDX_W = $clog2(MSG_LEN);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE      = SEQ_IDLE;
    localparam logic [2:0] ST_SEND      = SEQ_SEND;
    localparam logic [2:0] ST_WAIT_LOW  = SEQ_WAIT_LOW;
    localparam logic [2:0] ST_WAIT_HIGH = SEQ_WAIT_HIGH;
    localparam logic [2:0] ST_DONE      = SEQ_DONE;

    logic [2:0]         state;
    logic [CLASS_W-1:0] cur_class;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               pend_valid;
    logic [CLASS_W-1:0] pend_class;
    logic [7:0]         rom_char;

    logic               req_vld;
    logic [CLASS_W-1:0] req_class;
    logic               req_drop;

    lcd_msg_rom #(.NUM_CLASSES(NUM_CLASSES), .CLASS_W(CLASS_W)) u_rom (
        .class_id  (cur_class),
        .idx       (idx),
        .char_code (rom_char)
    );

    // A fresh strobe beats the buffered request.
    assign req_vld   = bus.class_valid || pend_valid;
    assign req_class = bus.class_valid ? bus.class_id : pend_class;

`ifdef LCD_SEQ_REPEAT_SUPPRESS_EN
    logic               last_vld;
    logic [CLASS_W-1:0] last_class;
    assign req_drop = last_vld && (req_class == last_class);
`else
    assign req_drop = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state          <= ST_IDLE;
            cur_class      <= '0;
            idx            <= '0;
            cnt            <= '0;
            pend_valid     <= 1'b0;
            pend_class     <= '0;
            bus.char_valid <= 1'b0;
            bus.char_out   <= LCD_SPACE;
            bus.busy       <= 1'b0;
            bus.msg_done   <= 1'b0;
            bus.err        <= 1'b0;
`ifdef LCD_SEQ_REPEAT_SUPPRESS_EN
            last_vld       <= 1'b0;
            last_class     <= '0;
`endif
        end else begin
            bus.char_valid <= 1'b0;
            bus.msg_done   <= 1'b0;

            // Requests arriving mid-message are buffered; the newest overwrites.
            if (bus.class_valid && state != ST_IDLE) begin
                pend_valid <= 1'b1;
                pend_class <= bus.class_id;
            end

            case (state)
                ST_IDLE: begin
                    if (req_vld) begin
                        pend_valid <= 1'b0;
                        if (!req_drop) begin
                            cur_class <= req_class;
                            idx       <= '0;
                            bus.busy  <= 1'b1;
                            state     <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (bus.char_ready) begin
                        bus.char_out   <= rom_char;
                        bus.char_valid <= 1'b1;
                        cnt            <= '0;
                        state          <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!bus.char_ready) begin
                        state <= ST_WAIT_HIGH;
                    end else if (cnt == CNT_W'(ACK_TIMEOUT)) begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
`ifdef LCD_SEQ_REPEAT_SUPPRESS_EN
                        last_vld <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (bus.char_ready) begin
                        if (idx == IDX_W'(MSG_LEN - 1)) begin
                            bus.msg_done <= 1'b1;
                            bus.busy     <= 1'b0;
                            state        <= ST_DONE;
`ifdef LCD_SEQ_REPEAT_SUPPRESS_EN
                            last_vld     <= 1'b1;
                            last_class   <= cur_class;
`endif
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_SEND;
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Scoreboard bench for lcd_msg_sequencer: expected characters are queued at request time
// and popped by a negedge monitor that also plays the LCD driver.
module tb_lcd_msg_sequencer;
    import lcd_pkg::*;

    localparam int CLASS_W     = 3;
    localparam int ACK_TIMEOUT = 8;
    localparam int HOLD        = 5;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    lcd_msg_sequencer_if #(.CLASS_W(CLASS_W)) bus ();

    lcd_msg_sequencer #(
        .NUM_CLASSES (4),
        .CLASS_W     (CLASS_W),
        .MSG_LEN     (16),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int         checks     = 0;
    int         errors     = 0;
    int         done_cnt   = 0;
    int         exp_done   = 0;
    int         chars_seen = 0;
    int         hold_cnt   = 0;
    bit         prev_valid = 1'b0;
    bit         never_drop = 1'b0;
    logic [7:0] exp_q [$];

    string msg_text [5] = '{"YES", "NO", "UP", "DOWN", "UNKNOWN"};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_char(input int cls, input int i);
        string s;
        s = msg_text[(cls < 4) ? cls : 4];
        return (i < s.len()) ? s[i] : 8'h20;
    endfunction

    // Monitor + LCD driver model: drop char_ready for HOLD cycles after each char_valid.
    always @(negedge clk) begin
        if (!rstb) begin
            bus.char_ready = 1'b1;
            hold_cnt       = 0;
            prev_valid     = 1'b0;
        end else begin
            if (bus.char_valid === 1'b1) begin
                chars_seen++;
                check("char_valid_b2b", prev_valid, 0);
                check("char_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("char_out", bus.char_out, exp_q.pop_front());
                if (!never_drop) begin
                    bus.char_ready = 1'b0;
                    hold_cnt       = HOLD;
                end
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) bus.char_ready = 1'b1;
            end
            prev_valid = bus.char_valid;
            if (bus.msg_done === 1'b1) begin
                done_cnt++;
                check("busy_at_done", bus.busy, 0);
            end
        end
    end

    task automatic send(input int cls, input int n_chars, input bit completes);
        bus.class_valid = 1'b1;
        bus.class_id    = CLASS_W'(cls);
        for (int i = 0; i < n_chars; i++) exp_q.push_back(exp_char(cls, i));
        if (completes) exp_done++;
        @(negedge clk);
        bus.class_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, n < 3000, 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt, exp_done);
    endtask

    task automatic wait_char_valid(input string tag);
        int n = 0;
        while (bus.char_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_char_seen"}, n < 50, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bus.class_valid = 1'b0;
        bus.class_id    = '0;
        repeat (3) @(negedge clk);
        check("rst_char_valid", bus.char_valid, 0);
        check("rst_char_out",   bus.char_out, 8'h20);
        check("rst_busy",       bus.busy, 0);
        check("rst_msg_done",   bus.msg_done, 0);
        check("rst_err",        bus.err, 0);
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        // Normal message with first-character latency.
        send(1, 16, 1);
        check("lat_busy_n1", bus.busy, 1);
        @(negedge clk);
        check("lat_char_valid_n2", bus.char_valid, 1);
        wait_quiet("normal");
        check("normal_err", bus.err, 0);

        // Pending overwrite: class 0 is replaced by class 3 and never shown.
        send(2, 16, 1);
        repeat (2) @(negedge clk);
        send(0, 0, 0);
        send(3, 16, 1);
        wait_quiet("pending");

        // Out-of-range class, plus a strobe landing in the DONE cycle.
        send(7, 16, 1);
        n = 0;
        while (bus.msg_done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("oor_done_seen", n < 500, 1);
        send(4, 16, 1);
        wait_quiet("oor_and_done_strobe");

        // Handshake timeout: the driver never drops char_ready.
        never_drop = 1'b1;
        send(2, 1, 0);
        wait_char_valid("timeout");
        repeat (8) @(negedge clk);
        check("timeout_err_early", bus.err, 0);
        @(negedge clk);
        check("timeout_err_set", bus.err, 1);
        check("timeout_busy", bus.busy, 0);
        repeat (5) @(negedge clk);
        check("timeout_no_done", done_cnt, exp_done);
        never_drop = 1'b0;
        send(3, 16, 1);
        wait_quiet("after_timeout");
        check("err_sticky", bus.err, 1);

        // Reset at character 6 with a request pending.
        base = chars_seen;
        send(0, 16, 0);
        send(1, 0, 0);
        n = 0;
        while (chars_seen < base + 6 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached", n < 500, 1);
        #2;
        rstb = 1'b0;
        #1;
        check("rst_mid_char_valid", bus.char_valid, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_msg_done", bus.msg_done, 0);
        check("rst_mid_err", bus.err, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        base = chars_seen;
        repeat (40) @(negedge clk);
        check("rst_no_chars_after", chars_seen - base, 0);
        check("rst_idle_busy", bus.busy, 0);

`ifdef LCD_SEQ_REPEAT_SUPPRESS_EN
        // Repeat suppression, and re-arming after a timeout.
        send(1, 16, 1);
        wait_quiet("sup_first");
        base = chars_seen;
        send(1, 0, 0);
        repeat (2) @(negedge clk);
        check("sup_repeat_busy", bus.busy, 0);
        repeat (20) @(negedge clk);
        check("sup_repeat_chars", chars_seen - base, 0);
        never_drop = 1'b1;
        send(2, 1, 0);
        repeat (30) @(negedge clk);
        check("sup_timeout_busy", bus.busy, 0);
        never_drop = 1'b0;
        send(1, 16, 1);
        wait_quiet("sup_after_timeout");
`endif

        check("final_done_cnt", done_cnt, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_msg_sequencer.md
# lcd_msg_sequencer

Sequences the character-level LCD driver: takes a keyword class index from the TinyML classifier, looks up that class's fixed-length ASCII message and streams it one character at a time over the driver's char_valid/char_ready handshake. It sits between the classifier result register and the LCD driver. It owns message selection, pacing, pending-request buffering and handshake-timeout detection.

## Interface
- NUM_CLASSES, 4: number of valid class indices; other indices display the UNKNOWN message.
- CLASS_W, 3: width of class_id; must satisfy 2**CLASS_W > NUM_CLASSES.
- MSG_LEN, 16: characters per message, one LCD line.
- ACK_TIMEOUT, 4095: maximum cycles to wait for char_ready to drop after a char_valid pulse.
- clk  in  1  clock.
- rstb  in  1  reset, asynchronous, active-low.
- class_valid  in  1  single-cycle strobe; class_id is valid.
- class_id  in  CLASS_W  detected keyword index.
- char_ready  in  1  from the LCD driver; high when the driver is idle.
- char_valid  out  1  to the LCD driver; single-cycle character strobe.
- char_out  out  8  ASCII character to the LCD driver.
- busy  out  1  high from message acceptance until the last character is acknowledged.
- msg_done  out  1  one-cycle pulse when a message completes.
- err  out  1  sticky; set on handshake timeout and cleared only by reset.

## Operation
- States: IDLE, SEND, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE
  - If a request is pending (a new strobe or the pending register), latch it into cur_class, clear idx, set busy and go to SEND.
  - The strobe takes priority over the pending register, and taking either clears the pending register.
- SEND
  - If char_ready is 1, register char_out = rom(cur_class, idx), pulse char_valid for one cycle and go to WAIT_LOW.
  - Otherwise stay in SEND.
- WAIT_LOW
  - When char_ready is 0, go to WAIT_HIGH.
  - A counter tracks cycles spent here. When it reaches ACK_TIMEOUT, set err, drop busy, abandon the message and go to IDLE. No msg_done is produced.
- WAIT_HIGH
  - When char_ready is 1: if idx == MSG_LEN-1, go to DONE; otherwise increment idx and go to SEND.
  - There is no timeout in this state, because the driver's own wait is bounded.
- DONE
  - Pulse msg_done and clear busy, then go to IDLE.
- Pending register, one entry deep
  - A class_valid outside IDLE writes pend_class and sets pend_valid.
  - A later strobe overwrites the entry, so the newest request wins.
  - The current message is never interrupted.
- A class_valid in the same cycle as DONE goes to the pending register and is started from IDLE on the next cycle.
- Arithmetic
  - idx is $clog2(MSG_LEN) bits and never wraps; the bound check happens before the increment.
  - The timeout counter is $clog2(ACK_TIMEOUT+1) bits, saturates and is cleared on entry to WAIT_LOW.
- Reset mid-message: all state returns to reset values immediately and the pending request is discarded. char_valid falls asynchronously, so a partial write is possible, and the next message rewrites the whole line.

## Timing
- Reset values
  - char_valid 0; char_out 8'h20; busy 0; msg_done 0; err 0.
  - Internal: state IDLE, idx 0, pend_valid 0.
- All outputs are registered.
- class_valid sampled at edge n in IDLE: busy is 1 from cycle n+1 and the state is SEND in n+1.
- With char_ready high, the first char_valid is high in cycle n+2.
- char_valid is never high for two consecutive cycles. It is never reasserted until char_ready has been observed 0 and then 1.
- Per-character cost: 2 cycles plus the driver busy time.
- msg_done is high in the cycle after the final WAIT_HIGH exit, and busy falls in the same cycle.

## Configuration
- LCD_SEQ_REPEAT_SUPPRESS_EN
  - Defined: keep last_class, the class of the last fully completed message, plus a last_vld flag. A request equal to last_class while last_vld is set is dropped: no busy, no characters. Timeouts clear last_vld.
  - Undefined: every request is displayed, and last_class/last_vld are not built.

## Structure
- Package lcd_pkg holds:
  - The state enum lcd_seq_state_t.
  - Constant LCD_MSG_LEN = 16 and ASCII constants (LCD_SPACE = 8'h20).
  - The message table as a localparam array of NUM_CLASSES+1 strings, the last one being "UNKNOWN" padded with spaces.
- Sub-module lcd_msg_rom
  - Combinational lookup of (class, idx) to an 8-bit char.
  - Out-of-range classes map to the UNKNOWN entry.

## Test plan
- Normal message: class_id=1 with a driver model holding char_ready low for 5 cycles per char -> exactly 16 char_valid pulses carrying table[1] in order, then one msg_done, busy low, err 0.
- Pending overwrite: class 2 is in progress; strobe class 0 then class 3 -> message 2 completes fully, then message 3 is sent, and class 0 is never displayed.
- Timeout: driver model never drops char_ready, ACK_TIMEOUT=8 -> err=1 nine cycles after the first char_valid, busy 0, no msg_done, and a new request is then accepted.
- Out of range: class_id=7 with NUM_CLASSES=4 -> "UNKNOWN" followed by 9 spaces (8'h20).
- Reset at character 6 -> char_valid, busy and msg_done are 0 immediately and pending is cleared. With no new strobe after release, no further char_valid.
- With LCD_SEQ_REPEAT_SUPPRESS_EN: class 1 twice after completion -> the second request is ignored. Class 1 after a timeout -> displayed.
